// File: rtl/tiny_rv_fetch_pkg.sv
// tiny_rv_fetch_pkg: shared opcode constants and fetch state encoding
package tiny_rv_fetch_pkg;
  localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_e;
endpackage

// File: rtl/tiny_rv_fetch_skid.sv
// tiny_rv_fetch_skid: one-entry {pc, inst} buffer catching a word returned while decode stalls
module tiny_rv_fetch_skid (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || i_unload) o_valid <= 1'b0;
    else if (i_load) o_valid <= 1'b1;
    if (i_load) begin
      o_pc   <= i_pc;
      o_inst <= i_inst;
    end
  end
endmodule

// File: rtl/tiny_rv_fetch.sv
// tiny_rv_fetch: single-outstanding instruction fetch with skid buffer and redirect/drain handling
module tiny_rv_fetch
  import tiny_rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = RV_NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst
);
  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         w_ack, w_slot_free, w_load, w_unload, w_buf_valid;
  logic [31:0]  w_redir_pc, w_pc_next, w_buf_pc, w_buf_inst;

  assign w_ack       = i_imem_ack && o_imem_req;
  assign w_slot_free = !fetch_valid || !i_pipe_stall;
  assign w_redir_pc  = {i_redirect_pc[31:2], 2'b00};
  assign w_pc_next   = r_pc + 32'd4;
  assign w_load      = !i_redirect_valid && r_state == REQ && w_ack && !w_slot_free;
  assign w_unload    = !i_redirect_valid && r_state == HOLD && !i_pipe_stall;

  tiny_rv_fetch_skid u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_unload(w_unload),
    .i_clear (i_redirect_valid),
    .i_pc    (o_imem_addr),
    .i_inst  (i_imem_rdata),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_inst  (w_buf_inst)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      o_imem_req  <= 1'b0;
      o_imem_addr <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'd0;
      fetch_inst  <= BUBBLE_INST;
    end else if (i_redirect_valid) begin
      r_pc        <= w_redir_pc;
      fetch_valid <= 1'b0;
      fetch_inst  <= BUBBLE_INST;
      if (o_imem_req && !i_imem_ack) r_state <= DRAIN;
      else begin
        r_state     <= REQ;
        o_imem_req  <= 1'b1;
        o_imem_addr <= w_redir_pc;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state     <= REQ;
          o_imem_req  <= 1'b1;
          o_imem_addr <= r_pc;
        end
        REQ: begin
          if (w_ack && w_slot_free) begin
            fetch_valid <= 1'b1;
            fetch_pc    <= o_imem_addr;
            fetch_inst  <= i_imem_rdata;
            r_pc        <= w_pc_next;
            o_imem_addr <= w_pc_next;
          end else if (w_ack) begin
            r_pc       <= w_pc_next;
            o_imem_req <= 1'b0;
            r_state    <= HOLD;
          end else if (w_slot_free) begin
            fetch_valid <= 1'b0;
            fetch_inst  <= BUBBLE_INST;
          end
        end
        HOLD: begin
          if (!i_pipe_stall) begin
            fetch_valid <= w_buf_valid;
            fetch_pc    <= w_buf_pc;
            fetch_inst  <= w_buf_inst;
            o_imem_req  <= 1'b1;
            o_imem_addr <= r_pc;
            r_state     <= REQ;
          end
        end
        DRAIN: begin
          // the stale word is dropped; the redirect target goes out next
          if (w_ack) begin
            o_imem_addr <= r_pc;
            r_state     <= REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tiny_rv_fetch.sv
// tb_tiny_rv_fetch: table-driven per-cycle vectors plus a stall-pattern streaming scoreboard
module tb_tiny_rv_fetch;
  localparam logic [31:0] D   = 32'h1000_0000;
  localparam logic [31:0] BUB = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, rv = 1'b0, ack = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic        req, fv;
  logic [31:0] addr, rdata, fpc, finst;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;
  assign rdata = addr + D;

  tiny_rv_fetch dut (
    .i_clk(clk), .i_reset(rst), .i_pipe_stall(stall),
    .i_redirect_valid(rv), .i_redirect_pc(rpc),
    .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata),
    .fetch_valid(fv), .fetch_pc(fpc), .fetch_inst(finst)
  );

  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] rpc;
    logic        ack, req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, inst;
  } vec_t;
  vec_t vq[$];

  task automatic t(input logic r, s, v, input logic [31:0] p, input logic a, q,
                   input logic [31:0] ad, input logic ev, input logic [31:0] epc);
    vec_t e;
    e = '{r, s, v, p, a, q, ad, ev, epc, ev ? epc + D : BUB};
    vq.push_back(e);
  endtask

  initial begin
    int acc, exp_pc;
    //rst stl rv rpc          ack req addr          v  pc
    t(1, 0, 0, 0,             0,  0, 32'h0,         0, 32'h0);
    t(1, 0, 0, 0,             0,  0, 32'h0,         0, 32'h0);
    t(0, 0, 0, 0,             0,  1, 32'h0,         0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h4,         1, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h8,         1, 32'h4);
    t(0, 0, 0, 0,             1,  1, 32'hC,         1, 32'h8);
    t(0, 0, 0, 0,             1,  1, 32'h10,        1, 32'hC);
    t(0, 1, 0, 0,             1,  0, 32'h0,         1, 32'hC);
    t(0, 1, 0, 0,             1,  0, 32'h0,         1, 32'hC);
    t(0, 1, 0, 0,             0,  0, 32'h0,         1, 32'hC);
    t(0, 1, 0, 0,             0,  0, 32'h0,         1, 32'hC);
    t(0, 0, 0, 0,             0,  1, 32'h14,        1, 32'h10);
    t(0, 0, 0, 0,             0,  1, 32'h14,        0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h18,        1, 32'h14);
    t(0, 1, 0, 0,             0,  1, 32'h18,        1, 32'h14);
    t(0, 1, 0, 0,             1,  0, 32'h0,         1, 32'h14);
    t(0, 1, 1, 32'h100,       0,  1, 32'h100,       0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h104,       1, 32'h100);
    t(0, 0, 1, 32'h202,       1,  1, 32'h200,       0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h204,       1, 32'h200);
    t(0, 0, 0, 0,             0,  1, 32'h204,       0, 32'h0);
    t(0, 0, 1, 32'h300,       0,  1, 32'h204,       0, 32'h0);
    t(0, 0, 0, 0,             0,  1, 32'h204,       0, 32'h0);
    t(0, 0, 1, 32'h400,       0,  1, 32'h204,       0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h400,       0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h404,       1, 32'h400);
    t(0, 0, 1, 32'hFFFF_FFFC, 1,  1, 32'hFFFF_FFFC, 0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h0,         1, 32'hFFFF_FFFC);
    t(0, 0, 0, 0,             1,  1, 32'h4,         1, 32'h0);
    t(0, 1, 0, 0,             1,  0, 32'h0,         1, 32'h0);
    t(1, 1, 0, 0,             0,  0, 32'h0,         0, 32'h0);
    t(0, 1, 0, 0,             0,  1, 32'h0,         0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h4,         1, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h8,         1, 32'h4);
    t(0, 0, 0, 0,             0,  1, 32'h8,         0, 32'h0);
    t(0, 0, 0, 0,             0,  1, 32'h8,         0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'hC,         1, 32'h8);
    t(0, 0, 0, 0,             0,  1, 32'hC,         0, 32'h0);
    t(0, 0, 0, 0,             0,  1, 32'hC,         0, 32'h0);
    t(0, 0, 0, 0,             1,  1, 32'h10,        1, 32'hC);

    foreach (vq[i]) begin
      rst = vq[i].rst; stall = vq[i].stall; rv = vq[i].rv; rpc = vq[i].rpc; ack = vq[i].ack;
      @(negedge clk);
      n_vec++;
      if (req !== vq[i].req || ((vq[i].req || vq[i].rst) && addr !== vq[i].addr) ||
          fv !== vq[i].valid || ((vq[i].valid || vq[i].rst) && fpc !== vq[i].pc) ||
          finst !== vq[i].inst) begin
        n_err++;
        $display("FAIL vec%0d: got req=%b addr=%h valid=%b pc=%h inst=%h, want req=%b addr=%h valid=%b pc=%h inst=%h",
                 i, req, addr, fv, fpc, finst, vq[i].req, vq[i].addr, vq[i].valid, vq[i].pc, vq[i].inst);
      end
    end

    // zero-wait stream with periodic stalls: every accepted word must be the next sequential pc
    rst = 1'b0; stall = 1'b0; ack = 1'b1; rv = 1'b1; rpc = 32'h500;
    @(negedge clk);
    rv = 1'b0;
    acc = 0;
    exp_pc = 32'h500;
    for (int i = 0; i < 40; i++) begin
      stall = (i % 3 == 2);
      if (fv && !stall) begin
        n_vec++;
        acc++;
        if (fpc !== 32'(exp_pc) || finst !== 32'(exp_pc) + D) begin
          n_err++;
          $display("FAIL stream%0d: got pc=%h inst=%h, want pc=%h inst=%h", i, fpc, finst, 32'(exp_pc), 32'(exp_pc) + D);
        end
        exp_pc += 4;
      end
      @(negedge clk);
    end
    n_vec++;
    if (acc < 10) begin
      n_err++;
      $display("FAIL stream_rate: got %0d accepted, want at least 10", acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tiny_rv_fetch.md
Name: tiny_rv_fetch

Overview:
Instruction fetch stage of the tiny_rv core. Produces the fetch_pc/fetch_inst pair consumed by the decode stage, which samples it on every clock where i_pipe_stall is low. It drives a single-outstanding-request instruction memory port with a req/ack handshake and holds a one-entry skid buffer so that a stall never loses a returned word. It accepts PC redirects from the execute stage for branches and jumps.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
BUBBLE_INST, 32'h0000_0013, instruction presented when no valid fetch exists (addi x0,x0,0)

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous, active-high reset
i_pipe_stall  input  1  decode will not sample fetch_* this cycle
i_redirect_valid  input  1  redirect PC this cycle (branch/jump taken)
i_redirect_pc  input  32  redirect target
o_imem_req  output  1  instruction memory request
o_imem_addr  output  32  word address of request, bits[1:0]=0
i_imem_ack  input  1  request complete; i_imem_rdata valid this cycle
i_imem_rdata  input  32  returned instruction word
fetch_valid  output  1  fetch_pc/fetch_inst hold a real instruction
fetch_pc  output  32  PC of presented instruction
fetch_inst  output  32  presented instruction, BUBBLE_INST when !fetch_valid

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high (i_reset). All outputs are registered.
- Reset values:
  - o_imem_req=0, o_imem_addr=RESET_PC
  - fetch_valid=0, fetch_pc=0, fetch_inst=BUBBLE_INST
  - buffer empty, state IDLE
  - Reset mid-request abandons the request; the memory must tolerate a dropped req.
- Bus rules:
  - Once o_imem_req is raised, req and addr stay stable until the cycle with i_imem_ack=1.
  - ack is only honoured while req=1.
  - Zero-wait memory (ack in the first req cycle) must sustain 1 instruction per cycle.
- Output slot consumption: the slot is free at an edge if fetch_valid=0 or i_pipe_stall=0.
- States:
  - IDLE: one cycle after reset. Next state REQ with req=1 and addr=pc.
  - REQ, ack with no redirect and slot free: load fetch_*=(addr, rdata, valid=1). pc+=4. Stay in REQ; the next address is presented the following cycle with req held high.
  - REQ, ack with no redirect and slot not free: write (addr, rdata) to the buffer. pc+=4. Drop req. Next state HOLD.
  - REQ, no ack, slot free: fetch_valid<=0 and fetch_inst<=BUBBLE_INST.
  - HOLD, stall=0: move the buffer to fetch_*, clear the buffer, raise req with addr=pc. Next state REQ.
  - HOLD, stall=1: no change.
  - DRAIN: req is held at the old address until ack. The data is discarded. Then raise req with addr=redirect pc. Next state REQ.
- Redirect (i_redirect_valid=1) has priority over everything except reset:
  - Latch pc=i_redirect_pc with bits[1:0] forced to 0.
  - fetch_valid<=0, fetch_inst<=BUBBLE_INST, buffer cleared. This applies regardless of stall.
  - If req=1 and ack=0 this cycle: go to DRAIN.
  - If ack=1 this cycle: discard rdata, addr<=new pc, req=1, go to REQ.
  - From IDLE or HOLD: go to REQ with the new pc.
  - A redirect during DRAIN overwrites the target pc and stays in DRAIN.
- pc arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.

Decomposition:
- Shared package alongside the rv_opcodes definitions holds:
  - RV_NOP_INST (32'h0000_0013)
  - the fetch state enum: IDLE, REQ, HOLD, DRAIN
- One natural sub-module: tiny_rv_fetch_skid, a one-entry {pc, inst} buffer with load/unload/clear.
- The state machine, pc register and output slot stay in tiny_rv_fetch.

Test Plan:
- Reset, zero-wait memory returning addr as data, no stall -> fetch_pc 0,4,8,C on consecutive cycles starting 2 cycles after reset release; fetch_valid=1 from the first.
- 3-cycle ack latency -> each instruction is presented for 1 cycle with valid=1, followed by 2+ bubble cycles with fetch_inst=0x13.
- Stall held 4 cycles while ack arrives for pc 0x8 and 0x4 is displayed -> 0x4 is held, 0x8 is buffered with req=0; on stall release 0x8 is shown the next cycle and a request for 0xC follows.
- Redirect to 0x100 while a 0x10 request is outstanding (ack 2 cycles later) -> fetch_valid=0 immediately, 0x10 data is never presented, next o_imem_addr=0x100.
- Redirect to 0x202 in the same cycle as ack -> rdata is dropped, the next request is at 0x200, and fetch_pc=0x200 when it completes.
- i_reset asserted for 1 cycle while in HOLD with stall=1 -> all outputs return to reset values and fetching restarts at RESET_PC.
